// File: rtl/spdif_rx.sv
`default_nettype none
// ============================================================================
// Module   : spdif_rx
// Purpose  : S/PDIF receiver. Oversamples a biphase-mark coded line at
//            CELL_CLKS clocks per half-bit cell, locks onto B/M/W preambles
//            and recovers the 16-bit left/right audio samples.
// Ports    : clk          system clock
//            reset        asynchronous active-low reset
//            spdif_in     raw line, asynchronous to clk
//            left_out     last left sample (held)
//            right_out    last right sample (held)
//            left_valid   1-clk pulse, left_out updated
//            right_valid  1-clk pulse, right_out updated
//            block_start  1-clk pulse with left_valid for a B preamble
//            parity_err   with a valid pulse: even-parity check failed
//            locked       decoding a continuous subframe stream
// Revision : 1.0  initial release
// ============================================================================
module spdif_rx #(
   parameter int CELL_CLKS   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spdif_in,
   output logic [15:0] left_out,
   output logic [15:0] right_out,
   output logic        left_valid,
   output logic        right_valid,
   output logic        block_start,
   output logic        parity_err,
   output logic        locked
);

   localparam int RUN_MAX = 4 * CELL_CLKS;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);
   localparam int LIM_S   = (3 * CELL_CLKS) / 2;
   localparam int LIM_M   = (5 * CELL_CLKS) / 2;
   localparam int LIM_L   = (7 * CELL_CLKS) / 2;

   localparam logic [RUN_W-1:0] RUN_MAX_V = RUN_W'(RUN_MAX);
   localparam logic [RUN_W-1:0] LIM_S_V   = RUN_W'(LIM_S);
   localparam logic [RUN_W-1:0] LIM_M_V   = RUN_W'(LIM_M);
   localparam logic [RUN_W-1:0] LIM_L_V   = RUN_W'(LIM_L);

   typedef enum logic [1:0] {RUN_S, RUN_M, RUN_L, RUN_E} run_t;
   typedef enum logic [1:0] {ST_HUNT, ST_PRE, ST_DATA, ST_EMIT} state_t;
   typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W} pre_t;

   // ---------------------------------------------------------------------
   // Front end: synchroniser, edge detect, run-length counter
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   line_q, line_d;
   logic [RUN_W-1:0]       run_q, run_d;
   logic                   line_edge;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], spdif_in};
      line_d    = sync_q[SYNC_STAGES-1];
      line_edge = sync_q[SYNC_STAGES-1] ^ line_q;
      // run_q holds the clock count since the previous edge, so in an edge
      // cycle it is exactly the length of the run that just ended.
      if (line_edge) begin
         run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX_V) begin
         run_d = run_q + 1'b1;
      end else begin
         run_d = run_q;
      end
   end

   run_t cls;
   logic run_long;   // current run already too long for any data slot
   logic run_dead;   // current run already too long to be anything but ERR

   always_comb begin
      if (run_q < LIM_S_V) begin
         cls = RUN_S;
      end else if (run_q < LIM_M_V) begin
         cls = RUN_M;
      end else if (run_q < LIM_L_V) begin
         cls = RUN_L;
      end else begin
         cls = RUN_E;
      end
      run_long = !line_edge && (run_q >= LIM_M_V);
      run_dead = !line_edge && (run_q >= LIM_L_V);
   end

   // ---------------------------------------------------------------------
   // Subframe FSM
   // ---------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [1:0]  pre_cnt_q, pre_cnt_d;      // preamble runs consumed
   run_t        pre_r1_q, pre_r1_d;        // second preamble run
   pre_t        pre_type_q, pre_type_d;
   logic [4:0]  slot_q, slot_d;
   logic        half_q, half_d;            // first S of a '1' slot seen
   logic        par_q, par_d;
   logic [15:0] sample_q, sample_d;

   logic [15:0] left_out_q, left_out_d;
   logic [15:0] right_out_q, right_out_d;
   logic        left_valid_q, left_valid_d;
   logic        right_valid_q, right_valid_d;
   logic        block_start_q, block_start_d;
   logic        parity_err_q, parity_err_d;
   logic        locked_q, locked_d;

   logic bit_done, bit_val, data_viol, pre_fail;

   always_comb begin
      state_d       = state_q;
      pre_cnt_d     = pre_cnt_q;
      pre_r1_d      = pre_r1_q;
      pre_type_d    = pre_type_q;
      slot_d        = slot_q;
      half_d        = half_q;
      par_d         = par_q;
      sample_d      = sample_q;
      left_out_d    = left_out_q;
      right_out_d   = right_out_q;
      left_valid_d  = 1'b0;
      right_valid_d = 1'b0;
      block_start_d = 1'b0;
      parity_err_d  = 1'b0;
      locked_d      = locked_q;
      bit_done      = 1'b0;
      bit_val       = 1'b0;
      data_viol     = 1'b0;
      pre_fail      = 1'b0;

      case (state_q)
         ST_HUNT: begin
            if (line_edge && cls == RUN_L) begin
               state_d   = ST_PRE;
               pre_cnt_d = 2'd1;
            end
         end

         ST_PRE: begin
            if (line_edge) begin
               case (pre_cnt_q)
                  2'd0: begin
                     if (cls == RUN_L) pre_cnt_d = 2'd1;
                     else              pre_fail  = 1'b1;
                  end
                  2'd1: begin
                     if (cls == RUN_E) begin
                        pre_fail = 1'b1;
                     end else begin
                        pre_r1_d  = cls;
                        pre_cnt_d = 2'd2;
                     end
                  end
                  2'd2: begin
                     if (cls == RUN_S) pre_cnt_d = 2'd3;
                     else              pre_fail  = 1'b1;
                  end
                  default: begin
                     // Third run is always S; runs 2 and 4 tell B/M/W apart.
                     if (pre_r1_q == RUN_S && cls == RUN_L) begin
                        pre_type_d = PRE_B;
                     end else if (pre_r1_q == RUN_L && cls == RUN_S) begin
                        pre_type_d = PRE_M;
                     end else if (pre_r1_q == RUN_M && cls == RUN_M) begin
                        pre_type_d = PRE_W;
                     end else begin
                        pre_fail = 1'b1;
                     end
                     if (!pre_fail) begin
                        state_d  = ST_DATA;
                        slot_d   = 5'd4;
                        half_d   = 1'b0;
                        par_d    = 1'b0;
                        sample_d = '0;
                     end
                  end
               endcase
               // An L that breaks the pattern may itself open a preamble.
               if (pre_fail) begin
                  locked_d = 1'b0;
                  if (cls == RUN_L) begin
                     state_d   = ST_PRE;
                     pre_cnt_d = 2'd1;
                  end else begin
                     state_d = ST_HUNT;
                  end
               end
            end else if (run_dead) begin
               state_d  = ST_HUNT;
               locked_d = 1'b0;
            end
         end

         ST_DATA: begin
            if (line_edge) begin
               if (!half_q) begin
                  if (cls == RUN_M) begin
                     bit_done = 1'b1;
                  end else if (cls == RUN_S) begin
                     half_d = 1'b1;
                  end else begin
                     data_viol = 1'b1;
                  end
               end else begin
                  if (cls == RUN_S) begin
                     bit_done = 1'b1;
                     bit_val  = 1'b1;
                  end else begin
                     data_viol = 1'b1;
                  end
               end

               if (bit_done) begin
                  half_d = 1'b0;
                  par_d  = par_q ^ bit_val;
                  if (slot_q >= 5'd12 && slot_q <= 5'd27) begin
                     sample_d = {bit_val, sample_q[15:1]};   // LSB first
                  end
                  if (slot_q == 5'd31) begin
                     state_d      = ST_EMIT;
                     parity_err_d = par_q ^ bit_val;
                     locked_d     = 1'b1;
                     if (pre_type_q == PRE_W) begin
                        right_out_d   = sample_q;
                        right_valid_d = 1'b1;
                     end else begin
                        left_out_d    = sample_q;
                        left_valid_d  = 1'b1;
                        block_start_d = (pre_type_q == PRE_B);
                     end
                  end else begin
                     slot_d = slot_q + 5'd1;
                  end
               end

               if (data_viol) begin
                  state_d  = ST_HUNT;
                  locked_d = 1'b0;
               end
            end else if (run_long) begin
               // No data slot run can be this long: give up now rather than
               // waiting for the closing edge or counter saturation.
               state_d  = ST_HUNT;
               locked_d = 1'b0;
            end
         end

         ST_EMIT: begin
            state_d   = ST_PRE;
            pre_cnt_d = 2'd0;
         end

         default: begin
            state_d = ST_HUNT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q        <= '0;
         line_q        <= 1'b0;
         run_q         <= '0;
         state_q       <= ST_HUNT;
         pre_cnt_q     <= 2'd0;
         pre_r1_q      <= RUN_S;
         pre_type_q    <= PRE_B;
         slot_q        <= 5'd0;
         half_q        <= 1'b0;
         par_q         <= 1'b0;
         sample_q      <= '0;
         left_out_q    <= '0;
         right_out_q   <= '0;
         left_valid_q  <= 1'b0;
         right_valid_q <= 1'b0;
         block_start_q <= 1'b0;
         parity_err_q  <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         line_q        <= line_d;
         run_q         <= run_d;
         state_q       <= state_d;
         pre_cnt_q     <= pre_cnt_d;
         pre_r1_q      <= pre_r1_d;
         pre_type_q    <= pre_type_d;
         slot_q        <= slot_d;
         half_q        <= half_d;
         par_q         <= par_d;
         sample_q      <= sample_d;
         left_out_q    <= left_out_d;
         right_out_q   <= right_out_d;
         left_valid_q  <= left_valid_d;
         right_valid_q <= right_valid_d;
         block_start_q <= block_start_d;
         parity_err_q  <= parity_err_d;
         locked_q      <= locked_d;
      end
   end

   assign left_out    = left_out_q;
   assign right_out   = right_out_q;
   assign left_valid  = left_valid_q;
   assign right_valid = right_valid_q;
   assign block_start = block_start_q;
   assign parity_err  = parity_err_q;
   assign locked      = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_spdif_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spdif_rx
// Purpose  : Self-checking bench for spdif_rx. A BMC encoder drives a table
//            of subframes into a CELL_CLKS=4 instance; a second instance at
//            CELL_CLKS=6 receives a stream joined mid-subframe.
// Revision : 1.0  initial release
// ============================================================================
module tb_spdif_rx;

   localparam logic [1:0] P_B = 2'd0;
   localparam logic [1:0] P_M = 2'd1;
   localparam logic [1:0] P_W = 2'd2;

   typedef struct {
      logic [1:0]  pre;
      logic [15:0] smp;
      bit          bad_par;
      bit          jit;
      int          cut;       // cells sent before the line freezes (0 = all)
      int          rst_clk;   // clock index to pulse reset (-1 = none)
      bit          exp;
      bit          exp_right;
      logic [15:0] exp_val;
      bit          exp_blk;
      bit          exp_perr;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        line4, line6;
   logic [15:0] l4, r4, l6, r6;
   logic        lv4, rv4, bs4, pe4, lk4;
   logic        lv6, rv6, bs6, pe6, lk6;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_edge_cyc = 0;
   int valid_cyc = -1;
   int lock_fall_cyc = -1;
   int lock_drops = 0;
   bit watch_lock = 0;
   bit prev_lk = 0;
   int n6 = 0;
   bit first6_r = 0;
   logic [15:0] first6_v = '0;

   vec_t tbl[$];
   vec_t exp_q[$];
   vec_t mon_e;

   spdif_rx #(.CELL_CLKS(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .reset(reset), .spdif_in(line4),
      .left_out(l4), .right_out(r4), .left_valid(lv4), .right_valid(rv4),
      .block_start(bs4), .parity_err(pe4), .locked(lk4));

   spdif_rx #(.CELL_CLKS(6), .SYNC_STAGES(2)) dut6 (
      .clk(clk), .reset(reset), .spdif_in(line6),
      .left_out(l6), .right_out(r6), .left_valid(lv6), .right_valid(rv6),
      .block_start(bs6), .parity_err(pe6), .locked(lk6));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench still running at %0t, want finished", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for the N=4 receiver: every valid pulse is matched in order
   // against the expectations queued by the driver.
   initial forever begin
      @(negedge clk);
      if (lv4 || rv4) begin
         valid_cyc = cyc;
         check("one_valid", lv4 & rv4, 0);
         check("locked_at_emit", lk4, 1);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got left=%0b right=%0b l=0x%h r=0x%h, want no pulse",
                     lv4, rv4, l4, r4);
         end else begin
            mon_e = exp_q.pop_front();
            check("channel_right", rv4, mon_e.exp_right);
            check("sample", rv4 ? r4 : l4, mon_e.exp_val);
            check("block_start", bs4, mon_e.exp_blk);
            check("parity_err", pe4, mon_e.exp_perr);
         end
      end
      if (watch_lock && !lk4) lock_drops++;
      if (prev_lk && !lk4) lock_fall_cyc = cyc;
      prev_lk = lk4;
   end

   initial forever begin
      @(negedge clk);
      if (lv6 || rv6) begin
         if (n6 == 0) begin
            first6_r = rv6;
            first6_v = rv6 ? r6 : l6;
         end
         n6++;
      end
   end

   task automatic drive(input bit sel, input logic v);
      @(negedge clk);
      if (sel) begin
         line6 = v;
      end else begin
         if (line4 !== v) last_edge_cyc = cyc;
         line4 = v;
      end
   endtask

   // Encode one subframe (aux/V/U/C zero, parity even unless bad_par) and
   // drive cells [first, cut) onto the selected line.
   task automatic send(input bit sel, input int n, input vec_t v, input int first);
      logic [63:0] cells;
      logic [7:0]  pat;
      logic        cur, bv, par;
      int          i, j, dur, last, ci;
      cur = sel ? line6 : line4;
      pat = (v.pre == P_B) ? 8'b11101000 : (v.pre == P_M) ? 8'b11100010 : 8'b11100100;
      for (int k = 0; k < 8; k++) cells[k] = pat[7-k] ^ cur;
      cur = cells[7];
      par = 1'b0;
      for (int s = 4; s < 32; s++) begin
         if (s >= 12 && s <= 27) bv = v.smp[s-12];
         else if (s == 31)       bv = par ^ v.bad_par;
         else                    bv = 1'b0;
         par = par ^ bv;
         cur = ~cur;
         cells[2*s] = cur;
         if (bv) cur = ~cur;
         cells[2*s+1] = cur;
      end
      if (!sel) watch_lock = v.jit;
      if (v.exp && !sel) exp_q.push_back(v);
      if (v.cut > 0) lock_fall_cyc = -1;
      last = (v.cut > 0) ? v.cut : 64;
      i = first;
      ci = 0;
      while (i < last) begin
         j = i;
         while (j < last && cells[j] == cells[i]) j++;
         dur = (j - i) * n;
         if (v.jit) dur = dur + int'($urandom_range(2, 0)) - 1;
         for (int k = 0; k < dur; k++) begin
            drive(sel, cells[i]);
            if (ci == v.rst_clk) begin
               reset = 1'b0;
               #1;
               check("reset_clears_outputs", {l4, r4, lv4, rv4, bs4, pe4, lk4}, 0);
            end
            if (ci == v.rst_clk + 3) reset = 1'b1;
            ci++;
         end
         i = j;
      end
      if (v.cut > 0) begin
         repeat (20) drive(sel, cells[last-1]);
         check("lock_drop_within_15", (lock_fall_cyc >= 0) && (lock_fall_cyc - last_edge_cyc <= 15), 1);
      end
   endtask

   // Closing edge that ends slot 31 of the final subframe, then idle.
   task automatic end_stream(input bit sel, input int n);
      drive(sel, sel ? ~line6 : ~line4);
      repeat (10 * n) drive(sel, sel ? line6 : line4);
   endtask

   task automatic add(input logic [1:0] pre, input logic [15:0] smp, input bit bad,
                      input bit jit, input int cut, input int rst, input bit exp, input bit perr);
      vec_t v;
      v.pre = pre; v.smp = smp; v.bad_par = bad; v.jit = jit; v.cut = cut; v.rst_clk = rst;
      v.exp = exp; v.exp_right = (pre == P_W); v.exp_val = smp;
      v.exp_blk = (pre == P_B); v.exp_perr = perr;
      tbl.push_back(v);
   endtask

   vec_t v6;

   initial begin
      reset = 1'b0;
      line4 = 1'b0;
      line6 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_state_n4", {l4, r4, lv4, rv4, bs4, pe4, lk4}, 0);
      check("reset_state_n6", {l6, r6, lv6, rv6, bs6, pe6, lk6}, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);

      //   pre  sample    bad jit cut rst  exp perr
      add(P_B, 16'h1234, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'hABCD, 0, 0, 0, -1, 1, 0);
      add(P_M, 16'h1234, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'hABCD, 0, 0, 0, -1, 1, 0);
      add(P_M, 16'h0001, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'h8001, 1, 0, 0, -1, 1, 1);
      add(P_M, 16'hFFFF, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'h0000, 0, 0, 0, -1, 1, 0);
      add(P_B, 16'h8000, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'h7FFE, 0, 0, 0, -1, 1, 0);
      for (int k = 0; k < 60; k++) begin
         add(P_M, 16'h0000, 0, 1, 0, -1, 1, 0);
         add(P_W, 16'hFFFF, 0, 1, 0, -1, 1, 0);
      end
      add(P_M, 16'h1357, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'h2468, 0, 0, 40, -1, 0, 0);   // line freezes mid-data
      add(P_M, 16'h3C3C, 0, 0, 0, -1, 1, 0);
      add(P_W, 16'hC3C3, 0, 0, 0, -1, 1, 0);
      add(P_M, 16'h5555, 0, 0, 0, 162, 0, 0);   // reset inside slot 20
      add(P_W, 16'h9999, 0, 0, 0, -1, 1, 0);
      add(P_M, 16'h6666, 0, 0, 0, -1, 1, 0);

      for (int t = 0; t < tbl.size(); t++) begin
         send(1'b0, 4, tbl[t], 0);
         if (t == 131) check("jitter_lock_drops", lock_drops, 0);
      end
      end_stream(1'b0, 4);
      check("emit_latency", valid_cyc - last_edge_cyc, 3);
      check("all_expected_emitted", exp_q.size(), 0);
      check("final_left_out", l4, 16'h6666);
      check("final_right_out", r4, 16'h9999);

      // N=6 receiver joins in the middle of a right subframe.
      v6.pre = P_W; v6.smp = 16'h7777; v6.bad_par = 0; v6.jit = 0; v6.cut = 0;
      v6.rst_clk = -1; v6.exp = 0; v6.exp_right = 1; v6.exp_val = 16'h7777;
      v6.exp_blk = 0; v6.exp_perr = 0;
      send(1'b1, 6, v6, 23);
      v6.pre = P_M; v6.smp = 16'h0F0F;
      send(1'b1, 6, v6, 0);
      v6.pre = P_W; v6.smp = 16'hF00D;
      send(1'b1, 6, v6, 0);
      end_stream(1'b1, 6);
      check("n6_pulse_count", n6, 2);
      check("n6_first_is_left", first6_r, 0);
      check("n6_first_sample", first6_v, 16'h0F0F);
      check("n6_right_out", r6, 16'hF00D);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spdif_rx.md
Name: spdif_rx

Overview:
- S/PDIF receiver: oversamples a biphase-mark (BMC) coded S/PDIF line and recovers 16-bit left/right audio samples.
- Counterpart of the in-house S/PDIF transmitter.
- Runs on a local clock at CELL_CLKS clocks per BMC cell.
- Used for loopback test and external digital audio input; feeds the same 16-bit sample path as the synth core.

Parameters:
CELL_CLKS, 4, nominal clk cycles per BMC half-bit cell; legal range 3..15
SYNC_STAGES, 2, number of flops in the spdif_in synchroniser (2 minimum)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0); all state cleared immediately
spdif_in  input  1  raw S/PDIF line, asynchronous to clk
left_out  output  16  last received left sample; held between updates
right_out  output  16  last received right sample; held between updates
left_valid  output  1  one-clk pulse: left_out updated this cycle
right_valid  output  1  one-clk pulse: right_out updated this cycle
block_start  output  1  one-clk pulse, coincident with left_valid, when the subframe carried a B preamble
parity_err  output  1  valid with left_valid/right_valid: 1 = even-parity check failed for that subframe
locked  output  1  1 = receiver is decoding a continuous subframe stream

Behaviour:
- Reset values: all outputs 0. FSM = HUNT. Run counter = 0.
- Front end:
  - spdif_in passes through SYNC_STAGES flops, then 1 edge-detect flop.
  - Run counter counts clks since the last edge and saturates at 4*CELL_CLKS.
- Run classification at each edge (N = CELL_CLKS, integer arithmetic):
  - len < (3N)/2 → S (1T)
  - len < (5N)/2 → M (2T)
  - len < (7N)/2 → L (3T)
  - otherwise → ERR
  - Counter saturation without an edge → ERR, raised immediately.
- Subframe = 32 slots of 2 cells.
  - Slots 0-3: preamble. Slots 4-11: aux, ignored. Slots 12-27: sample bits 0..15, LSB first. Slots 28-30: V, U, C, ignored. Slot 31: parity.
- Preamble run sequences:
  - B = L,S,S,L → left, block start
  - M = L,L,S,S → left
  - W = L,M,S,M → right
- Data slot decode:
  - M → bit 0.
  - S followed by S → bit 1.
  - S followed by non-S, any L, or any ERR → violation.
- FSM states:
  - HUNT: wait for an L run → PRE (1 run consumed).
  - PRE: collect 3 more runs. Match B/M/W → DATA with slot = 4. No match → HUNT. If the mismatch run is an L, treat it as the first run of a new preamble: stay in PRE, 1 run consumed.
  - DATA: decode slots 4..31. After slot 31 → EMIT. Violation → HUNT.
  - EMIT: one cycle. Load the sample register into left_out or right_out per preamble and pulse that channel's valid. Pulse block_start for B. Drive parity_err = XOR(slots 4..31). Set locked. → PRE expecting an L (0 runs consumed).
- Latency: valid pulse occurs exactly 1 clk after the edge-detect cycle of the edge that ends slot 31.
- locked:
  - Set in EMIT.
  - Cleared in the cycle any violation, ERR or preamble mismatch is detected.
  - Outputs (left_out/right_out) are never cleared on loss of lock.
- Parity failure does not suppress the sample; it only raises parity_err for that subframe.
- No channel-alternation check: consecutive W or consecutive B/M subframes are each emitted as decoded.
- Only one of left_valid/right_valid can be high in any cycle.
- Reset mid-subframe: immediate return to HUNT. The first valid pulse after release requires a complete preamble + 28 slots.
- Jitter tolerance: ±(N/2 − 1) clks per run edge, rounded down, guaranteed.

Test Plan:
1. Bench BMC encoder at N=4, alternating frames L=0x1234/R=0xABCD, B every 192 frames, correct parity → left_out=0x1234 and right_out=0xABCD. left_valid/right_valid alternate every 256 clks. block_start once per 384 subframes. locked=1 after first EMIT. parity_err=0.
2. Same stream with the parity bit inverted on one right subframe carrying 0x8001 → right_valid with right_out=0x8001 and parity_err=1. Neighbouring subframes parity_err=0. locked stays 1.
3. Line held constant for 20 clks mid-data → locked falls within 15 clks of the last edge, no valid pulse for that subframe. Relock and correct samples from the next full subframe.
4. ±1 clk random edge jitter at N=4 over 1000 subframes, L=0x0000/R=0xFFFF → zero decode errors, locked never drops.
5. reset pulled low for 3 clks mid-slot 20 → all outputs 0 immediately. First post-reset valid pulse comes only after the next complete subframe, with correct data.
6. Start capture at an arbitrary offset inside a subframe, N=6 → no valid pulse before the first complete preamble. The first emitted sample equals the transmitted value for that subframe.
